count_sequencer: RTL and testbench

//  Run-control for the ripple counter datapath: sequences an 8-bit count through programmed
//  one-shot or periodic intervals. Arms on START, counts to a latched terminal value, flags

---
 rtl/count_sequencer.sv | 141 ++++++++++++++
 tb/tb_count_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// Interval sequencer: counts 0..latched limit in one-shot or periodic mode, with hold, abort and DONE pulse.
// Optional sticky IRQ/OVR completion flags are enabled by defining COUNT_SEQ_IRQ_EN.
module count_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_hold,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_limit,
`ifdef COUNT_SEQ_IRQ_EN
  input  logic             i_ack,
  output logic             o_irq,
  output logic             o_ovr,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_nq
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] r_limit;
  logic             r_mode;
  logic             r_done;
  logic             w_terminal;
  logic             w_accept;

  assign w_accept = i_start & ~i_abort;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and next count share one priority chain: abort > start > hold > count.
  always_comb begin
    w_next_state = r_state;
    w_q_next     = r_q;
    w_terminal   = 1'b0;
    if (i_abort) begin
      w_next_state = S_IDLE;
      w_q_next     = '0;
    end else if (i_start) begin
      w_next_state = S_RUN;
      w_q_next     = '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (i_hold) begin
            w_next_state = S_PAUSED;
          end else if (r_q == r_limit) begin
            w_terminal = 1'b1;
            if (r_mode) begin
              w_q_next = '0;
            end else begin
              w_next_state = S_IDLE;
            end
          end else begin
            w_q_next = r_q + WIDTH'(1);
          end
        end
        S_PAUSED: begin
          if (!i_hold) begin
            w_next_state = S_RUN;
          end
        end
        S_IDLE: begin
          w_next_state = S_IDLE;
        end
        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q     <= '0;
      r_limit <= '0;
      r_mode  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_done <= w_terminal;
      if (w_accept) begin
        r_limit <= i_limit;
        r_mode  <= i_mode;
      end
    end
  end

`ifdef COUNT_SEQ_IRQ_EN
  logic r_irq;
  logic r_ovr;

  // A terminal coinciding with ACK keeps IRQ set and leaves OVR alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_irq <= 1'b0;
      r_ovr <= 1'b0;
    end else if (w_terminal) begin
      r_irq <= 1'b1;
      if (r_irq && !i_ack) begin
        r_ovr <= 1'b1;
      end
    end else if (i_ack) begin
      r_irq <= 1'b0;
      r_ovr <= 1'b0;
    end
  end

  always_comb begin
    o_irq = r_irq;
    o_ovr = r_ovr;
  end
`endif

  always_comb begin
    o_busy = (r_state != S_IDLE);
    o_done = r_done;
    o_q    = r_q;
    o_nq   = ~r_q;
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: a behavioural model queues expected outputs per edge.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       hold = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] limit = 8'd0;
  logic       ack = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic [7:0] nq;
`ifdef COUNT_SEQ_IRQ_EN
  logic       irq;
  logic       ovr;
`endif

  always #5 clk = ~clk;

  count_sequencer #(.WIDTH(8)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_abort (abort),
    .i_hold  (hold),
    .i_mode  (mode),
    .i_limit (limit),
`ifdef COUNT_SEQ_IRQ_EN
    .i_ack   (ack),
    .o_irq   (irq),
    .o_ovr   (ovr),
`endif
    .o_busy  (busy),
    .o_done  (done),
    .o_q     (q),
    .o_nq    (nq)
  );

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] nq;
    logic       busy;
    logic       done;
    logic       irq;
    logic       ovr;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  // Reference model state (0 = idle, 1 = run, 2 = paused)
  int         m_st   = 0;
  logic [7:0] m_q    = 8'd0;
  logic [7:0] m_lim  = 8'd0;
  logic       m_mode = 1'b0;
  logic       m_done = 1'b0;
  logic       m_irq  = 1'b0;
  logic       m_ovr  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic term;
    term = 1'b0;
    if (rst) begin
      m_st = 0; m_q = 8'd0; m_lim = 8'd0; m_mode = 1'b0;
    end else if (abort) begin
      m_st = 0; m_q = 8'd0;
    end else if (start) begin
      m_st = 1; m_q = 8'd0; m_lim = limit; m_mode = mode;
    end else if (m_st == 1) begin
      if (hold) m_st = 2;
      else if (m_q == m_lim) begin
        term = 1'b1;
        if (m_mode) m_q = 8'd0;
        else m_st = 0;
      end else m_q = m_q + 8'd1;
    end else if (m_st == 2) begin
      if (!hold) m_st = 1;
    end
    m_done = term;
    if (rst) begin
      m_irq = 1'b0; m_ovr = 1'b0;
    end else if (term) begin
      if (m_irq && !ack) m_ovr = 1'b1;
      m_irq = 1'b1;
    end else if (ack) begin
      m_irq = 1'b0; m_ovr = 1'b0;
    end
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    e.q = m_q; e.nq = ~m_q; e.busy = (m_st != 0); e.done = m_done;
    e.irq = m_irq; e.ovr = m_ovr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("q", 32'(q), 32'(e.q));
    check("nq", 32'(nq), 32'(e.nq));
    check("busy", 32'(busy), 32'(e.busy));
    check("done", 32'(done), 32'(e.done));
`ifdef COUNT_SEQ_IRQ_EN
    check("irq", 32'(irq), 32'(e.irq));
    check("ovr", 32'(ovr), 32'(e.ovr));
`endif
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic go(input logic [7:0] lim, input logic md);
    limit = lim; mode = md; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // reset
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    ticks(2);

    // one-shot LIMIT=3, then limit input changes must not matter
    go(8'd3, 1'b0);
    limit = 8'd9; mode = 1'b1;
    ticks(7);

    // periodic LIMIT=2
    go(8'd2, 1'b1);
    ticks(9);

    // periodic LIMIT=5 with hold at Q=2, resume, abort at Q=4
    go(8'd5, 1'b1);
    ticks(2);
    hold = 1'b1; ticks(4);
    hold = 1'b0; ticks(3);
    abort = 1'b1; tick();
    abort = 1'b0; ticks(3);

    // restart at Q=7 of LIMIT=10 with LIMIT=1 one-shot
    go(8'd10, 1'b0);
    ticks(7);
    go(8'd1, 1'b0);
    ticks(4);

    // restart from PAUSED, START with HOLD in the same cycle
    go(8'd6, 1'b1);
    ticks(2);
    hold = 1'b1; ticks(2);
    hold = 1'b1; go(8'd4, 1'b1);
    ticks(2);
    hold = 1'b0; ticks(6);

    // abort while START also asserted, and abort suppressing a pending terminal
    go(8'd2, 1'b1);
    ticks(2);
    abort = 1'b1; start = 1'b1; tick();
    abort = 1'b0; start = 1'b0; ticks(2);

    // LIMIT=255 periodic: full 256-edge period plus wrap
    go(8'd255, 1'b1);
    ticks(260);

    // LIMIT=0 periodic: DONE every cycle
    go(8'd0, 1'b1);
    ticks(6);
    abort = 1'b1; tick();
    abort = 1'b0;

    // sticky IRQ/OVR on periodic LIMIT=1
    ack = 1'b1; tick();
    ack = 1'b0;
    go(8'd1, 1'b1);
    ticks(4);
    ack = 1'b1; tick();
    ack = 1'b0; tick();
    tick();
    ack = 1'b1; tick();
    ack = 1'b0; ticks(2);
    abort = 1'b1; tick();
    abort = 1'b0; ticks(2);

    // randomised control traffic
    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 49) == 0);
      hold  = ($urandom_range(0, 3) == 0);
      mode  = 1'($urandom_range(0, 1));
      limit = 8'($urandom_range(0, 12));
      ack   = ($urandom_range(0, 5) == 0);
      tick();
    end
    start = 1'b0; abort = 1'b0; hold = 1'b0; ack = 1'b0;

    // mid-run reset
    go(8'd8, 1'b1);
    ticks(3);
    rst = 1'b1; tick();
    rst = 1'b0; ticks(3);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
